// File: rtl/ptcalc_div_pkg.sv
// ptcalc_div_pkg
// Shared definitions for the pT-calculation signed divider:
//   DIVIDEND_W / DIVISOR_W : operand widths (quotient / remainder widths)
//   CNT_W                  : width of the iteration counter
//   state_e                : divider FSM states
//   Q_MAX / Q_MIN          : quotient saturation values (div-by-zero, overflow)
// The widths live here only, so the interface, the step cell and the top
// always agree on them.
package ptcalc_div_pkg;

  localparam int DIVIDEND_W = 26;
  localparam int DIVISOR_W  = 13;
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

endpackage

// File: rtl/ptcalc_top_sdiv_seq_if.sv
// ptcalc_top_sdiv_seq_if
// Operand and result handshakes of the signed divider.
//   in_valid/in_ready   : operand pair handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div0, ovf)
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the divider itself
interface ptcalc_top_sdiv_seq_if;
  import ptcalc_div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div0;
  logic                  ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div0, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div0, ovf
  );

endinterface

// File: rtl/ptcalc_top_sdiv_step.sv
// ptcalc_top_sdiv_step
// One radix-2 restoring division step (purely combinational).
//   partRem_i : current partial remainder (unsigned)
//   bitIn_i   : next dividend bit, MSB first
//   dvsMag_i  : divisor magnitude
//   partRem_o : partial remainder after shift and trial subtract/restore
//   qBit_o    : quotient bit produced by this step
module ptcalc_top_sdiv_step
  import ptcalc_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   partRem_i,
  input  logic                 bitIn_i,
  input  logic [DIVISOR_W-1:0] dvsMag_i,
  output logic [DIVISOR_W:0]   partRem_o,
  output logic                 qBit_o
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;
  logic                 unusedMsb;

  // The incoming partial remainder is always below |divisor| <= 2^(DIVISOR_W-1),
  // so its top bit is structurally zero and the shifted value still fits.
  assign unusedMsb = partRem_i[DIVISOR_W];
  assign shifted   = {partRem_i[DIVISOR_W-1:0], bitIn_i};

  // Borrow out of the extra top bit means the trial result went negative.
  assign trial     = {1'b0, shifted} - {2'b00, dvsMag_i};
  assign qBit_o    = ~trial[DIVISOR_W+1];
  assign partRem_o = qBit_o ? trial[DIVISOR_W:0] : shifted;

endmodule

// File: rtl/ptcalc_top_sdiv_seq.sv
// ptcalc_top_sdiv_seq
// Iterative signed divider (radix-2 restoring, one quotient bit per clock).
// Quotient truncates toward zero, remainder takes the dividend's sign.
//   ap_clk   : clock
//   ap_rst_n : asynchronous active-low reset
//   bus      : slave side of ptcalc_top_sdiv_seq_if (operands in, result out)
// Divide-by-zero saturates the quotient and flags div0; the single
// unrepresentable case (most-negative / -1) saturates and flags ovf.
module ptcalc_top_sdiv_seq
  import ptcalc_div_pkg::*;
(
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  ptcalc_top_sdiv_seq_if.slave   bus
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W:0]    partRem_q, partRem_d;
  logic [DIVISOR_W-1:0]  dvsMag_q, dvsMag_d;
  logic                  dvdNeg_q, dvdNeg_d;
  logic                  quoNeg_q, quoNeg_d;
  logic                  zeroCase_q, zeroCase_d;
  logic                  ovfCase_q, ovfCase_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  div0_q, div0_d;
  logic                  ovf_q, ovf_d;

  logic [DIVIDEND_W-1:0] dvdAbs;
  logic [DIVISOR_W-1:0]  dvsAbs;
  logic [DIVISOR_W:0]    stepRem;
  logic                  stepBit;

  // Magnitudes of the raw operands; the most-negative values map to exact
  // unsigned powers of two.
  assign dvdAbs = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
  assign dvsAbs = bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;

  ptcalc_top_sdiv_step uStep (
    .partRem_i (partRem_q),
    .bitIn_i   (work_q[DIVIDEND_W-1]),
    .dvsMag_i  (dvsMag_q),
    .partRem_o (stepRem),
    .qBit_o    (stepBit)
  );

  // work_q starts as |dividend| and shifts left each step; quotient bits fill
  // in from the LSB, so after DIVIDEND_W steps it holds |quotient|.
  // CALC spends DIVIDEND_W cycles stepping plus a final cycle (counter == 0)
  // that applies the sign fix-up or the saturated result. A zero divisor
  // loads the counter with 0, so it only pays that final cycle; work_q then
  // carries the raw dividend for the remainder.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    partRem_d   = partRem_q;
    dvsMag_d    = dvsMag_q;
    dvdNeg_d    = dvdNeg_q;
    quoNeg_d    = quoNeg_q;
    zeroCase_d  = zeroCase_q;
    ovfCase_d   = ovfCase_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvdNeg_d   = bus.dividend[DIVIDEND_W-1];
          quoNeg_d   = bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
          dvsMag_d   = dvsAbs;
          partRem_d  = '0;
          zeroCase_d = (bus.divisor == '0);
          ovfCase_d  = (bus.dividend == Q_MIN) && (bus.divisor == '1);
          if (bus.divisor == '0) begin
            work_d = bus.dividend;
            cnt_d  = '0;
          end else begin
            work_d = dvdAbs;
            cnt_d  = CNT_W'(DIVIDEND_W);
          end
          state_d = CALC;
        end
      end

      CALC: begin
        if (cnt_q != '0) begin
          partRem_d = stepRem;
          work_d    = {work_q[DIVIDEND_W-2:0], stepBit};
          cnt_d     = cnt_q - 1'b1;
        end else begin
          if (zeroCase_q) begin
            quotient_d  = dvdNeg_q ? Q_MIN : Q_MAX;
            remainder_d = work_q[DIVISOR_W-1:0];
            div0_d      = 1'b1;
            ovf_d       = 1'b0;
          end else if (ovfCase_q) begin
            quotient_d  = Q_MAX;
            remainder_d = '0;
            div0_d      = 1'b0;
            ovf_d       = 1'b1;
          end else begin
            quotient_d  = quoNeg_q ? -work_q : work_q;
            remainder_d = dvdNeg_q ? -partRem_q[DIVISOR_W-1:0]
                                   : partRem_q[DIVISOR_W-1:0];
            div0_d      = 1'b0;
            ovf_d       = 1'b0;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      partRem_q   <= '0;
      dvsMag_q    <= '0;
      dvdNeg_q    <= 1'b0;
      quoNeg_q    <= 1'b0;
      zeroCase_q  <= 1'b0;
      ovfCase_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      partRem_q   <= partRem_d;
      dvsMag_q    <= dvsMag_d;
      dvdNeg_q    <= dvdNeg_d;
      quoNeg_q    <= quoNeg_d;
      zeroCase_q  <= zeroCase_d;
      ovfCase_q   <= ovfCase_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div0      = div0_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ptcalc_top_sdiv_seq.sv
// tb_ptcalc_top_sdiv_seq
// Self-checking bench for ptcalc_top_sdiv_seq. Expected results come from an
// integer reference model and are queued when an operand pair is accepted,
// then popped when the divider presents its result.
module tb_ptcalc_top_sdiv_seq;

  typedef struct packed {
    logic [25:0] q;
    logic [12:0] r;
    logic        d0;
    logic        ov;
  } res_t;

  localparam logic [25:0] QMAX = 26'h1FFFFFF;
  localparam logic [25:0] QMIN = 26'h2000000;

  logic ap_clk;
  logic ap_rst_n;
  int   total;
  int   bad;
  res_t sb[$];

  ptcalc_top_sdiv_seq_if bus();

  ptcalc_top_sdiv_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference model built on the simulator's own signed division, which
  // truncates toward zero with the remainder following the dividend.
  function automatic res_t model(input logic [25:0] a, input logic [12:0] b);
    res_t   res;
    longint sa;
    longint sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = '0;
    if (sbv == 0) begin
      res.q  = (sa >= 0) ? QMAX : QMIN;
      res.r  = a[12:0];
      res.d0 = 1'b1;
    end else if (sa == -33554432 && sbv == -1) begin
      res.q  = QMAX;
      res.r  = '0;
      res.ov = 1'b1;
    end else begin
      res.q = 26'(sa / sbv);
      res.r = 13'(sa % sbv);
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)",
               tag, got, got, want, want);
    end
  endtask

  // Drives one operand pair, checks latency and result against the queue,
  // optionally stalls the consumer for hold cycles (with a stray in_valid
  // that must be ignored), then completes the output handshake.
  task automatic applyStimulus(input logic [25:0] a, input logic [12:0] b,
                               input int hold);
    res_t want;
    int   waitCnt;
    int   lat;
    int   expLat;
    waitCnt = 0;
    @(negedge ap_clk);
    while (!bus.in_ready && waitCnt < 64) begin
      @(negedge ap_clk);
      waitCnt++;
    end
    if (waitCnt >= 64) checkOutput("acceptWait", 32'd0, 32'd1);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    sb.push_back(model(a, b));
    expLat = (b == '0) ? 1 : 27;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge ap_clk);
      lat++;
    end while (!bus.out_valid && lat < 64);
    checkOutput("latency", 32'(lat), 32'(expLat));
    if (sb.size() == 0) begin
      checkOutput("sbUnderflow", 32'd0, 32'd1);
      want = '0;
    end else begin
      want = sb.pop_front();
    end
    checkOutput("inReadyBusy", 32'(bus.in_ready), 32'd0);
    checkOutput("quotient", 32'(bus.quotient), 32'(want.q));
    checkOutput("remainder", 32'(bus.remainder), 32'(want.r));
    checkOutput("div0", 32'(bus.div0), 32'(want.d0));
    checkOutput("ovf", 32'(bus.ovf), 32'(want.ov));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = a + 26'd1;
      bus.divisor  = 13'd3;
      @(negedge ap_clk);
      checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
      checkOutput("holdInReady", 32'(bus.in_ready), 32'd0);
      checkOutput("holdQuot", 32'(bus.quotient), 32'(want.q));
      checkOutput("holdRem", 32'(bus.remainder), 32'(want.r));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.out_ready = 1'b0;
    checkOutput("inReadyAfter", 32'(bus.in_ready), 32'd1);
    checkOutput("validAfter", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [25:0] ra;
    logic [12:0] rb;
    int          seen;
    total         = 0;
    bad           = 0;
    ap_rst_n      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge ap_clk);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstQuot", 32'(bus.quotient), 32'd0);
    checkOutput("rstRem", 32'(bus.remainder), 32'd0);
    checkOutput("rstDiv0", 32'(bus.div0), 32'd0);
    checkOutput("rstOvf", 32'(bus.ovf), 32'd0);
    ap_rst_n = 1'b1;

    $display("[TB] directed operand pairs");
    applyStimulus(26'd1000, 13'd7, 0);
    checkOutput("q1000by7", 32'(bus.quotient), 32'd142);
    checkOutput("r1000by7", 32'(bus.remainder), 32'd6);
    applyStimulus(26'(-1000), 13'd7, 0);
    applyStimulus(26'd1000, 13'(-7), 0);
    applyStimulus(26'(-1000), 13'(-7), 0);
    applyStimulus(26'd5, 13'd0, 0);
    checkOutput("q5by0", 32'(bus.quotient), 32'd33554431);
    applyStimulus(26'(-5), 13'd0, 0);
    applyStimulus(QMIN, 13'h1FFF, 0);
    checkOutput("ovfQuot", 32'(bus.quotient), 32'd33554431);
    applyStimulus(QMIN, 13'h1000, 0);
    checkOutput("minBy4096", 32'(bus.quotient), 32'd8192);

    $display("[TB] backpressure");
    applyStimulus(26'd123456, 13'(-321), 10);

    $display("[TB] reset during CALC");
    @(negedge ap_clk);
    bus.dividend = 26'd1000;
    bus.divisor  = 13'd7;
    bus.in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
    repeat (11) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("midRstQuot", 32'(bus.quotient), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge ap_clk);
      if (bus.out_valid) seen++;
    end
    checkOutput("noResultAfterRst", 32'(seen), 32'd0);
    applyStimulus(26'd100, 13'd3, 0);
    checkOutput("q100by3", 32'(bus.quotient), 32'd33);
    checkOutput("r100by3", 32'(bus.remainder), 32'd1);

    $display("[TB] random operand pairs");
    for (int n = 0; n < 1000; n++) begin
      ra = 26'($urandom);
      if ($urandom_range(0, 15) == 0) ra = QMIN;
      case ($urandom_range(0, 2))
        0:       rb = 13'($urandom);
        1:       rb = 13'(int'($urandom_range(0, 32)) - 16);
        default: rb = 13'($urandom_range(0, 4095));
      endcase
      applyStimulus(ra, rb, 0);
    end

    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
